// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared funct3 codes and FSM encoding for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = F3_LB;
    localparam logic [2:0] F3_SH  = F3_LH;
    localparam logic [2:0] F3_SW  = F3_LW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_ls_align.sv
// rtl/mem_port_arbiter_ls_align.sv - byte-enable, store replication and load extension for one LS access
module mem_port_arbiter_ls_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] lane;

    // Selected byte/halfword moved down to bit 0 before extension.
    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = 32'd0;
        rdata_ext  = 32'd0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (funct3 == F3_LB) ? {{24{lane[7]}}, lane[7:0]}
                                              : {24'd0, lane[7:0]};
            end
            F3_LH, F3_LHU: begin
                misaligned = offset[0];
                be         = 4'b0011 << offset;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = (funct3 == F3_LH) ? {{16{lane[15]}}, lane[15:0]}
                                               : {16'd0, lane[15:0]};
            end
            F3_LW: begin
                misaligned = (offset != 2'b00);
                be         = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = lane;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic             we_q;
    logic             capture_ls;
    logic             ls_win;

    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic [31:0]       req_rdata_unused;
    logic              req_bad;
    logic [3:0]        rsp_be_unused;
    logic [31:0]       rsp_wdata_unused;
    logic [31:0]       rsp_rdata;
    logic              rsp_bad_unused;
    logic [1:0]        if_addr_lsb_unused;
    logic [ADDR_W-1:0] if_word_addr;
    logic [ADDR_W-1:0] ls_word_addr;

    assign if_addr_lsb_unused = if_addr[1:0];
    assign if_word_addr       = {if_addr[ADDR_W-1:2], 2'b00};
    assign ls_word_addr       = {ls_addr[ADDR_W-1:2], 2'b00};

    // LS normally wins; a waiting fetch that has been passed over STARVE_MAX times takes priority.
    assign ls_win = ls_req && !(if_req && (starve_cnt == STARVE_LIM));

    mem_port_arbiter_ls_align u_req_align (
        .funct3     (ls_funct3),
        .offset     (ls_addr[1:0]),
        .wdata      (ls_wdata),
        .rdata      (32'd0),
        .be         (req_be),
        .wdata_rep  (req_wdata),
        .rdata_ext  (req_rdata_unused),
        .misaligned (req_bad)
    );

    mem_port_arbiter_ls_align u_rsp_align (
        .funct3     (f3_q),
        .offset     (off_q),
        .wdata      (32'd0),
        .rdata      (mem_rdata),
        .be         (rsp_be_unused),
        .wdata_rep  (rsp_wdata_unused),
        .rdata_ext  (rsp_rdata),
        .misaligned (rsp_bad_unused)
    );

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        capture_ls = 1'b0;
        if_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        ls_gnt     = 1'b0;
        ls_rvalid  = 1'b0;
        ls_rdata   = '0;
        ls_err     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (rst_n && ls_win) begin
                    ls_gnt = 1'b1;
                    if (if_req && (starve_cnt != STARVE_LIM)) begin
                        starve_nxt = starve_cnt + CNT_W'(1);
                    end
                    if (req_bad) begin
                        ls_err = 1'b1;
                    end else begin
                        mem_req    = 1'b1;
                        mem_we     = ls_we;
                        mem_be     = req_be;
                        mem_addr   = ls_word_addr;
                        mem_wdata  = ls_we ? req_wdata : '0;
                        capture_ls = 1'b1;
                        state_nxt  = BUSY_LS;
                    end
                end else if (rst_n && if_req) begin
                    if_gnt     = 1'b1;
                    mem_req    = 1'b1;
                    mem_be     = 4'b1111;
                    mem_addr   = if_word_addr;
                    starve_nxt = '0;
                    state_nxt  = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                    state_nxt = IDLE;
                end
            end
            BUSY_LS: begin
                if (mem_rvalid) begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = we_q ? '0 : rsp_rdata;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            we_q       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (capture_ls) begin
                off_q <= ls_addr[1:0];
                f3_q  <= ls_funct3;
                we_q  <= ls_we;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_funct3  (ls_funct3),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } ls_vec_t;

    ls_vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ctl"}, 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we, mem_be}), 32'd0);
        check({name, "_dat"}, if_rdata | ls_rdata | mem_addr | mem_wdata, 32'd0);
    endtask

    task automatic run_ls(input int idx, input ls_vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(posedge clk); #1;
        ls_req    = 1'b1;
        ls_we     = v.we;
        ls_funct3 = v.f3;
        ls_addr   = v.addr;
        ls_wdata  = v.wdata;
        @(negedge clk);
        check({tag, "_gnt"}, 32'(ls_gnt), 32'd1);
        check({tag, "_err"}, 32'(ls_err), 32'(v.err));
        check({tag, "_mem_req"}, 32'(mem_req), 32'(!v.err));
        if (!v.err) begin
            check({tag, "_we"}, 32'(mem_we), 32'(v.we));
            check({tag, "_be"}, 32'(mem_be), 32'(v.be));
            check({tag, "_addr"}, mem_addr, {v.addr[31:2], 2'b00});
            if (v.we) check({tag, "_wdata"}, mem_wdata, v.mwdata);
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        check({tag, "_wait_rvalid"}, 32'({ls_rvalid, ls_err, mem_req}), 32'd0);
        if (!v.err) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b1;
            mem_rdata  = v.mrdata;
            @(negedge clk);
            check({tag, "_rvalid"}, 32'(ls_rvalid), 32'd1);
            check({tag, "_rdata"}, ls_rdata, v.rdata);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FF00, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_FF00, 1'b0, 4'b1000, 32'h0, 32'h0000_0080};
        vecs[2]  = '{1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h1234_5678, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[3]  = '{1'b0, 3'b010, 32'h201, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001};
        vecs[5]  = '{1'b0, 3'b101, 32'h200, 32'h0, 32'h8001_F234, 1'b0, 4'b0011, 32'h0, 32'h0000_F234};
        vecs[6]  = '{1'b1, 3'b000, 32'h101, 32'h1234_56A5, 32'h0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[7]  = '{1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[8]  = '{1'b0, 3'b001, 32'h203, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'h20C, 32'h0, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 3'b000, 32'h201, 32'h0, 32'h0000_7F00, 1'b0, 4'b0010, 32'h0, 32'h0000_007F};
        vecs[12] = '{1'b1, 3'b110, 32'h000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};

        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'd0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_funct3  = 3'b000;
        ls_addr    = 32'd0;
        ls_wdata   = 32'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;

        // Reset state and stale-response rejection.
        repeat (2) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        check_quiet("stale_rvalid");
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_quiet("idle_after_stale");

        // Fetch with memory latency 2.
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        check("if_gnt", 32'(if_gnt), 32'd1);
        check("if_mem_req", 32'({mem_req, mem_we, mem_be}), 32'b1_0_1111);
        check("if_mem_addr", mem_addr, 32'h100);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("if_lat1", 32'({if_rvalid, mem_req}), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        @(negedge clk);
        check("if_rvalid", 32'(if_rvalid), 32'd1);
        check("if_rdata", if_rdata, 32'h1357_9BDF);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("if_rvalid_pulse", 32'(if_rvalid), 32'd0);

        // Simultaneous requests: LS first, IF the cycle after the LS response.
        @(posedge clk); #1;
        if_req    = 1'b1;
        if_addr   = 32'h40;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_funct3 = 3'b010;
        ls_addr   = 32'h200;
        @(negedge clk);
        check("prio_ls_gnt", 32'({ls_gnt, if_gnt}), 32'b10);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        check("prio_busy_no_gnt", 32'({ls_gnt, if_gnt, mem_req}), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        @(negedge clk);
        check("prio_ls_rsp", 32'({ls_rvalid, if_gnt}), 32'b10);
        check("prio_ls_rdata", ls_rdata, 32'h0BAD_F00D);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("prio_if_gnt", 32'(if_gnt), 32'd1);
        check("prio_if_addr", mem_addr, 32'h40);
        @(posedge clk); #1;
        if_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0013;
        @(negedge clk);
        check("prio_if_rvalid", 32'(if_rvalid), 32'd1);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        // Starvation: four LS grants, then IF forced, then LS again.
        @(posedge clk); #1;
        if_req    = 1'b1;
        if_addr   = 32'h80;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_funct3 = 3'b010;
        ls_addr   = 32'h300;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            check($sformatf("starve_grant%0d", g), 32'({ls_gnt, if_gnt}), (g == 4) ? 32'b01 : 32'b10);
            @(posedge clk); #1;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_0000;
            @(negedge clk);
            if (g == 4) check("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0;
        ls_req = 1'b0;

        // Table-driven LS vectors.
        for (int i = 0; i < 13; i++) begin
            run_ls(i, vecs[i]);
        end

        // Reset during BUSY_LS abandons the transaction.
        @(posedge clk); #1;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_funct3 = 3'b010;
        ls_addr   = 32'h200;
        @(negedge clk);
        check("rst_mid_gnt", 32'(ls_gnt), 32'd1);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(dut.state), 32'd0);
        check_quiet("rst_mid_outputs");
        @(posedge clk); #1;
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_mid_no_rvalid", 32'({ls_rvalid, if_rvalid}), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
